// File: rtl/light_pkg.sv
// Shared types and default sizes for the LED pattern sequencer.
package light_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        ROTATE = 2'd1,
        BOUNCE = 2'd2,
        BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_e;

    localparam int DEF_DATA_LEN = 16;
    localparam int DEF_CNT_W    = 24;
    localparam int DEF_PWM_W    = 4;

endpackage

// File: rtl/light_seq_if.sv
// Control/LED bus of the sequencer. The duty input and the PWM_W parameter
// exist only when LIGHT_SEQ_PWM_EN is defined.
// No valid/ready handshake: every control input is sampled on each rising
// clk edge, and out/tick are registered outputs meant to be read between edges.
// dbg_dir exposes the bounce direction register for checkers.
interface light_seq_if
    import light_pkg::*;
#(
    parameter int DATA_LEN = DEF_DATA_LEN,
    parameter int CNT_W    = DEF_CNT_W
`ifdef LIGHT_SEQ_PWM_EN
    , parameter int PWM_W  = DEF_PWM_W
`endif
);
    logic                en;
    mode_e               mode;
    logic [CNT_W-1:0]    div;
    logic                load;
    logic [DATA_LEN-1:0] seed;
    logic [DATA_LEN-1:0] out;
    logic                tick;
    dir_e                dbg_dir;
`ifdef LIGHT_SEQ_PWM_EN
    logic [PWM_W-1:0]    duty;
`endif

    modport master (
`ifdef LIGHT_SEQ_PWM_EN
        output duty,
`endif
        output en, mode, div, load, seed,
        input  out, tick, dbg_dir
    );

    modport slave (
`ifdef LIGHT_SEQ_PWM_EN
        input  duty,
`endif
        input  en, mode, div, load, seed,
        output out, tick, dbg_dir
    );

endinterface

// File: rtl/light_prescaler.sv
// Step-rate prescaler: pulses step once every max(div,1) enabled cycles.
// The >= compare lets a shrinking div wrap at once instead of overrunning.
module light_prescaler #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] div,
    output logic             step
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_max;

    assign w_max = (div == '0) ? '0 : div - CNT_W'(1);
    assign step  = en && (r_cnt >= w_max);

    // Count enabled cycles; clear on load or on wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= step ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/light_seq.sv
// LED pattern sequencer top: prescaled stepping through FILL, ROTATE,
// BOUNCE and BLINK patterns with a synchronous seed load.
// Optional brightness gating is enabled by defining LIGHT_SEQ_PWM_EN.
module light_seq
    import light_pkg::*;
#(
    parameter int DATA_LEN = DEF_DATA_LEN,
    parameter int CNT_W    = DEF_CNT_W
`ifdef LIGHT_SEQ_PWM_EN
    , parameter int PWM_W  = DEF_PWM_W
`endif
) (
    input logic        clk,
    input logic        rst,
    light_seq_if.slave bus
);
    localparam logic [DATA_LEN-1:0] ONE = DATA_LEN'(1);

    logic                r_tick;
    logic [DATA_LEN-1:0] r_pattern;
    dir_e                r_dir;
    mode_e               r_prev_mode;

    logic                w_step;
    logic                w_onehot;
    dir_e                w_dir_eff;
    logic [DATA_LEN-1:0] w_pat_nxt;
    dir_e                w_dir_nxt;
    logic                w_tick_nxt;

    light_prescaler #(.CNT_W(CNT_W)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .clr  (bus.load),
        .div  (bus.div),
        .step (w_step)
    );

    assign w_onehot = (r_pattern != '0) && ((r_pattern & (r_pattern - ONE)) == '0);

    // Next pattern, direction and tick: load beats step; a mode change resets dir.
    always_comb begin
        w_pat_nxt  = r_pattern;
        w_tick_nxt = 1'b0;
        w_dir_eff  = (bus.mode != r_prev_mode) ? LEFT : r_dir;
        w_dir_nxt  = w_dir_eff;
        if (bus.load) begin
            w_pat_nxt = bus.seed;
            w_dir_nxt = LEFT;
        end else if (w_step) begin
            w_tick_nxt = 1'b1;
            case (bus.mode)
                FILL: begin
                    w_pat_nxt = {r_pattern[DATA_LEN-2:0], ~r_pattern[DATA_LEN-1]};
                end
                ROTATE: begin
                    w_pat_nxt = (r_pattern == '0) ? ONE
                                : {r_pattern[DATA_LEN-2:0], r_pattern[DATA_LEN-1]};
                end
                BOUNCE: begin
                    if (!w_onehot) begin
                        w_pat_nxt = ONE;
                        w_dir_nxt = LEFT;
                    end else if (w_dir_eff == LEFT) begin
                        if (r_pattern[DATA_LEN-1]) begin
                            w_dir_nxt = RIGHT;
                            w_pat_nxt = r_pattern >> 1;
                        end else begin
                            w_pat_nxt = r_pattern << 1;
                        end
                    end else begin
                        if (r_pattern[0]) begin
                            w_dir_nxt = LEFT;
                            w_pat_nxt = r_pattern << 1;
                        end else begin
                            w_pat_nxt = r_pattern >> 1;
                        end
                    end
                end
                default: begin
                    w_pat_nxt = ~r_pattern;
                end
            endcase
        end
    end

    // Pattern, direction, mode history and tick registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern   <= '0;
            r_dir       <= LEFT;
            r_prev_mode <= FILL;
            r_tick      <= 1'b0;
        end else begin
            r_pattern   <= w_pat_nxt;
            r_dir       <= w_dir_nxt;
            r_prev_mode <= bus.mode;
            r_tick      <= w_tick_nxt;
        end
    end

`ifdef LIGHT_SEQ_PWM_EN
    logic [PWM_W-1:0]    r_pwm_cnt;
    logic [DATA_LEN-1:0] r_out;

    // Free-running brightness counter and gated, registered LED vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_out     <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            r_out     <= w_pat_nxt & {DATA_LEN{r_pwm_cnt < bus.duty}};
        end
    end

    assign bus.out = r_out;
`else
    assign bus.out = r_pattern;
`endif

    assign bus.tick    = r_tick;
    assign bus.dbg_dir = r_dir;

endmodule
